// File: rtl/bnn_conv3x3_stream.sv
// Binary 3x3 VALID convolution on a raster pixel stream: XNOR-popcount per output channel, then threshold.
// Two register stages (window, output), accept->out_valid in 2 cycles; in_ready drops only when both stages are full and output is stalled.
module bnn_conv3x3_stream #(
    parameter int IMG_W = 13,
    parameter int IMG_H = 13,
    parameter int CIN   = 8,
    parameter int COUT  = 16,
    localparam int CW   = $clog2(9*CIN+1),
    parameter logic [COUT*9*CIN-1:0] WEIGHTS = {COUT*9*CIN{1'b1}},
    parameter logic [COUT*CW-1:0]    THRESH  = {COUT{CW'(5*CIN)}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sof,
    input  logic [CIN-1:0]  in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [COUT-1:0] out_data,
    output logic            out_last
);
    localparam int CLW  = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int NWIN = 9*CIN;

    logic [CLW-1:0]  col;
    logic [RW-1:0]   row;
    logic [CLW-1:0]  pos_col;
    logic [RW-1:0]   pos_row;
    logic            accept;
    logic            load;
    logic            win_done;
    logic            frame_end;
    logic            s1_valid;
    logic            s1_last;
    logic [CIN-1:0]  win [3][3];
    logic [CIN-1:0]  lb0 [IMG_W];
    logic [CIN-1:0]  lb1 [IMG_W];
    logic [NWIN-1:0] win_flat;
    logic [COUT-1:0] score;

    function automatic logic [CW-1:0] popcount(input logic [NWIN-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < NWIN; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    assign in_ready  = !(s1_valid && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign load      = s1_valid && (!out_valid || out_ready);

    // in_sof forces the accepted pixel to (0,0) regardless of where the counters were
    assign pos_col   = in_sof ? '0 : col;
    assign pos_row   = in_sof ? '0 : row;
    assign win_done  = (pos_row >= RW'(2)) && (pos_col >= CLW'(2));
    assign frame_end = (pos_row == RW'(IMG_H-1)) && (pos_col == CLW'(IMG_W-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (pos_col == CLW'(IMG_W-1)) begin
                col <= '0;
                row <= (pos_row == RW'(IMG_H-1)) ? '0 : pos_row + 1'b1;
            end else begin
                col <= pos_col + 1'b1;
                row <= pos_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[pos_col] <= lb0[pos_col];
            lb0[pos_col] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ky = 0; ky < 3; ky++) begin
                for (int kx = 0; kx < 3; kx++) begin
                    win[ky][kx] <= '0;
                end
            end
        end else if (accept) begin
            for (int ky = 0; ky < 3; ky++) begin
                win[ky][0] <= win[ky][1];
                win[ky][1] <= win[ky][2];
            end
            win[0][2] <= lb1[pos_col];
            win[1][2] <= lb0[pos_col];
            win[2][2] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else if (accept) begin
            s1_valid <= win_done;
            s1_last  <= win_done && frame_end;
        end else if (load) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end
    end

    always_comb begin
        win_flat = '0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                win_flat[(ky*3+kx)*CIN +: CIN] = win[ky][kx];
            end
        end
    end

    always_comb begin
        score = '0;
        for (int o = 0; o < COUT; o++) begin
            score[o] = popcount(~(win_flat ^ WEIGHTS[o*NWIN +: NWIN])) >= THRESH[o*CW +: CW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= score;
            out_last  <= s1_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
